// File: rtl/mem_bridge.sv
// mem_bridge: RV32I load/store port to a synchronous single-port RAM.
// Lane steering, load extension and wait-state sequencing.
module mem_bridge #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              iClk,
    input  logic              nRst,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iWData,
    input  logic              iRead,
    input  logic              iWrite,
    input  logic [1:0]        iSize,
    input  logic              iUnsigned,
    output logic [31:0]       oRData,
    output logic              oRdy,
    output logic              oMisalign,
    output logic [ADDR_W-3:0] oRamAddr,
    output logic [31:0]       oRamWData,
    output logic [3:0]        oRamBe,
    output logic              oRamEn,
    output logic              oRamWe,
    input  logic [31:0]       iRamRData
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        wr_q;

    logic        bad_req;
    logic [3:0]  be_req;
    logic [31:0] wd_req;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    // Decode the incoming request: alignment check and write lane steering
    always_comb begin
        bad_req = 1'b0;
        be_req  = 4'b1111;
        wd_req  = iWData;
        case (iSize)
            2'b00: begin
                be_req = 4'b0001 << iAddr[1:0];
                wd_req = {4{iWData[7:0]}};
            end
            2'b01: begin
                bad_req = iAddr[0];
                be_req  = iAddr[1] ? 4'b1100 : 4'b0011;
                wd_req  = {2{iWData[15:0]}};
            end
            2'b10: bad_req = |iAddr[1:0];
            default: bad_req = 1'b1;
        endcase
        if (!iWrite) begin
            be_req = 4'b1111;
        end
    end

    // Pick the addressed lane out of the RAM word and extend it
    always_comb begin
        ld_byte = iRamRData[{off_q, 3'b000} +: 8];
        ld_half = off_q[1] ? iRamRData[31:16] : iRamRData[15:0];
        case (size_q)
            2'b00:   ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
            default: ld_val = iRamRData;
        endcase
    end

    // Access sequencer; every output is a registered copy of its next value
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            wr_q      <= 1'b0;
            oRData    <= '0;
            oRdy      <= 1'b0;
            oMisalign <= 1'b0;
            oRamAddr  <= '0;
            oRamWData <= '0;
            oRamBe    <= '0;
            oRamEn    <= 1'b0;
            oRamWe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iWrite || iRead) begin
                        wr_q   <= iWrite;
                        size_q <= iSize;
                        uns_q  <= iUnsigned;
                        off_q  <= iAddr[1:0];
                        if (bad_req) begin
                            state     <= DONE;
                            oRdy      <= 1'b1;
                            oMisalign <= 1'b1;
                        end else begin
                            state     <= ACCESS;
                            oRamAddr  <= iAddr[ADDR_W-1:2];
                            oRamBe    <= be_req;
                            oRamWData <= wd_req;
                            oRamEn    <= 1'b1;
                            oRamWe    <= iWrite;
                        end
                    end
                end
                ACCESS: begin
                    oRamEn <= 1'b0;
                    oRamWe <= 1'b0;
                    if (wr_q) begin
                        state <= DONE;
                        oRdy  <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= 4'(WAIT_STATES);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= DONE;
                        oRData <= ld_val;
                        oRdy   <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    oRdy      <= 1'b0;
                    oMisalign <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: three bridges (1, 4, 15 wait states) on shared core inputs,
// each with its own RAM model, checked against a byte-addressed reference.
module tb_mem_bridge;

    localparam int WS [3] = '{1, 4, 15};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;

    logic [31:0] o_rd  [3];
    logic        o_rdy [3];
    logic        o_mis [3];
    logic [29:0] o_ra  [3];
    logic [31:0] o_wd  [3];
    logic [3:0]  o_be  [3];
    logic        o_en  [3];
    logic        o_we  [3];
    logic [31:0] ram_rd [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = WS[g];
        logic [31:0] mem  [256];
        logic [31:0] pipe [W];

        mem_bridge #(
            .ADDR_W(32),
            .WAIT_STATES(W)
        ) u_dut (
            .iClk(clk),
            .nRst(rst_n),
            .iAddr(addr),
            .iWData(wdata),
            .iRead(rd),
            .iWrite(wr),
            .iSize(size),
            .iUnsigned(uns),
            .oRData(o_rd[g]),
            .oRdy(o_rdy[g]),
            .oMisalign(o_mis[g]),
            .oRamAddr(o_ra[g]),
            .oRamWData(o_wd[g]),
            .oRamBe(o_be[g]),
            .oRamEn(o_en[g]),
            .oRamWe(o_we[g]),
            .iRamRData(ram_rd[g])
        );

        // RAM with W cycles of read latency; garbage when not reading
        always @(posedge clk) begin
            if (o_en[g] && o_we[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (o_be[g][b]) begin
                        mem[o_ra[g][7:0]][8*b +: 8] <= o_wd[g][8*b +: 8];
                    end
                end
            end
            pipe[0] <= (o_en[g] && !o_we[g]) ? mem[o_ra[g][7:0]] : $urandom;
            for (int i = 1; i < W; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end

        assign ram_rd[g] = pipe[W-1];
    end

    int tests = 0;
    int fails = 0;

    logic [7:0]  ref_mem [1024];
    logic [31:0] last_rd = '0;

    int          exp_k [3];
    int          exp_en;
    logic        exp_mis;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [29:0] exp_ra;

    int          en_n   [3];
    int          en_k   [3];
    logic        en_we  [3];
    logic [3:0]  en_be  [3];
    logic [31:0] en_wd  [3];
    logic [29:0] en_ra  [3];
    int          rdy_n  [3];
    int          rdy_k  [3];
    logic        rdy_mis[3];
    logic [31:0] rdy_rd [3];
    logic [3:0]  rdy_be [3];

    task automatic run_op(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] s,
                          input logic u);
        logic        bad;
        int          n;
        int          be_i;
        logic [63:0] v;
        bad = (s == 2'b11) || (s == 2'b01 && a[0]) ||
              (s == 2'b10 && a[1:0] != 2'b00);
        n = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        exp_mis = bad;
        exp_en  = bad ? 0 : 1;
        exp_we  = w;
        exp_ra  = a[31:2];
        be_i    = ((1 << n) - 1) << a[1:0];
        exp_be  = w ? be_i[3:0] : 4'b1111;
        exp_wd  = (n == 1) ? {4{d[7:0]}} : (n == 2) ? {2{d[15:0]}} : d;
        for (int g = 0; g < 3; g++) begin
            exp_k[g] = bad ? 1 : w ? 2 : 2 + WS[g];
        end
        if (!bad && w) begin
            for (int i = 0; i < n; i++) begin
                ref_mem[int'(a[9:0]) + i] = d[8*i +: 8];
            end
        end else if (!bad) begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                v[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
            end
            if (!u && v[8*n-1]) begin
                v = v | ~((64'd1 << (8*n)) - 64'd1);
            end
            last_rd = v[31:0];
        end
        for (int g = 0; g < 3; g++) begin
            en_n[g] = 0; en_k[g] = 0; rdy_n[g] = 0; rdy_k[g] = 0;
        end
        @(negedge clk);
        addr = a; wdata = d; size = s; uns = u; wr = w; rd = r;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (o_en[g]) begin
                    en_n[g]++; en_k[g] = k; en_we[g] = o_we[g];
                    en_be[g] = o_be[g]; en_wd[g] = o_wd[g];
                    en_ra[g] = o_ra[g];
                end
                if (o_rdy[g]) begin
                    rdy_n[g]++; rdy_k[g] = k; rdy_mis[g] = o_mis[g];
                    rdy_rd[g] = o_rd[g]; rdy_be[g] = o_be[g];
                end
            end
            if (k == 1) begin
                wr = 1'b0; rd = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            tests++;
            if ({o_rd[g], o_rdy[g], o_mis[g], o_ra[g], o_wd[g], o_be[g],
                 o_en[g], o_we[g]} !== '0) begin
                fails++;
                $display("FAIL reset_outputs g%0d: rdata %h rdy %b mis %b en %b we %b be %b ra %h wd %h, want all 0",
                         g, o_rd[g], o_rdy[g], o_mis[g], o_en[g], o_we[g],
                         o_be[g], o_ra[g], o_wd[g]);
            end
        end
    endtask

    task automatic prep_memory();
        for (int i = 0; i < 256; i++) begin
            run_op(1'b1, 1'b0, 32'(i * 4), $urandom, 2'b10, 1'b0);
        end
    endtask

    task automatic test_word_store_load();
        run_op(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (en_be[g] !== 4'b1111 || en_ra[g] !== 30'h40 || en_k[g] != 1) begin
                fails++;
                $display("FAIL word_store g%0d: be %b ra %h cyc %0d, want 1111 40 1",
                         g, en_be[g], en_ra[g], en_k[g]);
            end
        end
        run_op(1'b0, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (rdy_k[g] != 2 + WS[g] || rdy_rd[g] !== 32'hDEADBEEF ||
                rdy_mis[g] !== 1'b0) begin
                fails++;
                $display("FAIL word_load g%0d: cyc %0d data %h mis %b, want %0d deadbeef 0",
                         g, rdy_k[g], rdy_rd[g], rdy_mis[g], 2 + WS[g]);
            end
        end
    endtask

    task automatic test_byte_store();
        run_op(1'b1, 1'b0, 32'h102, 32'h000000A5, 2'b00, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (en_be[g] !== 4'b0100 || en_wd[g] !== 32'hA5A5A5A5 ||
                en_n[g] != 1) begin
                fails++;
                $display("FAIL byte_store g%0d: be %b wd %h en_cycles %0d, want 0100 a5a5a5a5 1",
                         g, en_be[g], en_wd[g], en_n[g]);
            end
        end
    endtask

    task automatic test_extension();
        logic [31:0] want [4];
        logic [31:0] ad   [4];
        logic [1:0]  sz   [4];
        logic        us   [4];
        want = '{32'hFFFFFFF1, 32'h000000F1, 32'hFFFF80F1, 32'h00007F00};
        ad   = '{32'h2, 32'h2, 32'h2, 32'h0};
        sz   = '{2'b00, 2'b00, 2'b01, 2'b01};
        us   = '{1'b0, 1'b1, 1'b0, 1'b1};
        run_op(1'b1, 1'b0, 32'h0, 32'h80F17F00, 2'b10, 1'b0);
        for (int t = 0; t < 4; t++) begin
            run_op(1'b0, 1'b1, ad[t], 32'h0, sz[t], us[t]);
            for (int g = 0; g < 3; g++) begin
                tests++;
                if (rdy_rd[g] !== want[t]) begin
                    fails++;
                    $display("FAIL extend%0d g%0d: got %h want %h",
                             t, g, rdy_rd[g], want[t]);
                end
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] ad [3];
        logic [1:0]  sz [3];
        logic        ww [3];
        ad = '{32'h101, 32'h103, 32'h0};
        sz = '{2'b10, 2'b01, 2'b11};
        ww = '{1'b0, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            run_op(ww[t], ~ww[t], ad[t], 32'h12345678, sz[t], 1'b0);
            for (int g = 0; g < 3; g++) begin
                tests++;
                if (rdy_k[g] != 1 || rdy_n[g] != 1 || rdy_mis[g] !== 1'b1 ||
                    en_n[g] != 0 || rdy_rd[g] !== last_rd) begin
                    fails++;
                    $display("FAIL misalign%0d g%0d: cyc %0d mis %b en_cycles %0d data %h, want 1 1 0 %h",
                             t, g, rdy_k[g], rdy_mis[g], en_n[g], rdy_rd[g], last_rd);
                end
            end
        end
    endtask

    task automatic test_read_write_both();
        run_op(1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 2'b10, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (en_we[g] !== 1'b1 || rdy_k[g] != 2) begin
                fails++;
                $display("FAIL rw_both g%0d: we %b cyc %0d, want 1 2",
                         g, en_we[g], rdy_k[g]);
            end
        end
        run_op(1'b0, 1'b1, 32'h204, 32'h0, 2'b10, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (rdy_rd[g] !== 32'hCAFEF00D) begin
                fails++;
                $display("FAIL rw_both_readback g%0d: got %h want cafef00d",
                         g, rdy_rd[g]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  s;
        int          m;
        for (int it = 0; it < 150; it++) begin
            m = $urandom_range(0, 2);
            s = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 4) != 0) begin
                a = (s == 2'b10) ? (a & ~32'h3) : (s == 2'b01) ? (a & ~32'h1) : a;
            end
            run_op(m != 1, m != 0, a, $urandom, s, 1'($urandom));
            for (int g = 0; g < 3; g++) begin
                tests++;
                if (rdy_n[g] != 1 || rdy_k[g] != exp_k[g] || rdy_mis[g] !== exp_mis) begin
                    fails++;
                    $display("FAIL rand_rdy it%0d g%0d: pulses %0d cyc %0d mis %b, want 1 %0d %b",
                             it, g, rdy_n[g], rdy_k[g], rdy_mis[g], exp_k[g], exp_mis);
                end
                tests++;
                if (en_n[g] != exp_en) begin
                    fails++;
                    $display("FAIL rand_en_count it%0d g%0d: got %0d want %0d",
                             it, g, en_n[g], exp_en);
                end
                tests++;
                if (rdy_rd[g] !== last_rd) begin
                    fails++;
                    $display("FAIL rand_rdata it%0d g%0d: got %h want %h",
                             it, g, rdy_rd[g], last_rd);
                end
                if (exp_en == 1) begin
                    tests++;
                    if (en_k[g] != 1 || en_we[g] !== exp_we || en_be[g] !== exp_be ||
                        en_ra[g] !== exp_ra || rdy_be[g] !== exp_be) begin
                        fails++;
                        $display("FAIL rand_ram it%0d g%0d: cyc %0d we %b be %b ra %h done_be %b, want 1 %b %b %h",
                                 it, g, en_k[g], en_we[g], en_be[g], en_ra[g],
                                 rdy_be[g], exp_we, exp_be, exp_ra);
                    end
                    if (exp_we) begin
                        tests++;
                        if (en_wd[g] !== exp_wd) begin
                            fails++;
                            $display("FAIL rand_wdata it%0d g%0d: got %h want %h",
                                     it, g, en_wd[g], exp_wd);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_en  [3];
        int n_rdy [3];
        int e1 [3];
        int e2 [3];
        int r1 [3];
        int r2 [3];
        for (int g = 0; g < 3; g++) begin
            n_en[g] = 0; n_rdy[g] = 0; e1[g] = 0; e2[g] = 0; r1[g] = 0; r2[g] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[32'h300 + i] = 8'h11 * 8'(i + 1);
        end
        @(negedge clk);
        addr = 32'h300; wdata = 32'h44332211; size = 2'b10; uns = 1'b0;
        wr = 1'b1; rd = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                if (o_en[g]) begin
                    n_en[g]++;
                    if (n_en[g] == 1) e1[g] = k; else e2[g] = k;
                end
                if (o_rdy[g]) begin
                    n_rdy[g]++;
                    if (n_rdy[g] == 1) r1[g] = k; else r2[g] = k;
                end
            end
            if (k == 6) wr = 1'b0;
        end
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (n_en[g] != 2 || e1[g] != 1 || e2[g] != 4 ||
                n_rdy[g] != 2 || r1[g] != 2 || r2[g] != 5) begin
                fails++;
                $display("FAIL back_to_back g%0d: en %0d@%0d,%0d rdy %0d@%0d,%0d, want 2@1,4 2@2,5",
                         g, n_en[g], e1[g], e2[g], n_rdy[g], r1[g], r2[g]);
            end
        end
    endtask

    task automatic test_async_reset();
        int n_rdy;
        n_rdy = 0;
        @(negedge clk);
        addr = 32'h100; wdata = 32'h0; size = 2'b10; uns = 1'b0;
        wr = 1'b0; rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            tests++;
            if ({o_rd[g], o_rdy[g], o_mis[g], o_ra[g], o_wd[g], o_be[g],
                 o_en[g], o_we[g]} !== '0) begin
                fails++;
                $display("FAIL async_reset_outputs g%0d: rdata %h rdy %b en %b be %b ra %h, want all 0",
                         g, o_rd[g], o_rdy[g], o_en[g], o_be[g], o_ra[g]);
            end
        end
        last_rd = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            for (int g = 0; g < 3; g++) begin
                if (o_rdy[g]) n_rdy++;
            end
        end
        tests++;
        if (n_rdy != 0) begin
            fails++;
            $display("FAIL async_reset_no_rdy: got %0d pulses want 0", n_rdy);
        end
        run_op(1'b0, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tests++;
            if (rdy_k[g] != 2 + WS[g] || rdy_rd[g] !== 32'hDEADBEEF) begin
                fails++;
                $display("FAIL async_reset_reload g%0d: cyc %0d data %h, want %0d deadbeef",
                         g, rdy_k[g], rdy_rd[g], 2 + WS[g]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        rd    = 1'b0;
        wr    = 1'b0;
        size  = '0;
        uns   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        prep_memory();
        test_word_store_load();
        test_byte_store();
        test_extension();
        test_misalign();
        test_read_write_both();
        test_random();
        test_back_to_back();
        // 0x100 is restored so the post-reset reload has a known value
        run_op(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 2'b10, 1'b0);
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Memory-side bridge between the RV32I core's load/store port and a synchronous single-port 32-bit RAM. Accepts one word, halfword or byte access at a time from the core and drives word address, byte enables and lane-replicated write data to the RAM. Waits a parameterised read latency, then returns the aligned, sign- or zero-extended load result with a one-cycle ready pulse. Misaligned or illegal requests are rejected without touching the RAM.

## Interface
- `ADDR_W`, default 32: byte-address width of the core address.
- `WAIT_STATES`, default 1: RAM read latency in cycles, counted after the enable cycle; legal range is 1 to 15.

One clock; reset is asynchronous and active-low.

- `iClk` in 1: clock, rising edge.
- `nRst` in 1: asynchronous active-low reset.
- `iAddr` in ADDR_W: byte address.
- `iWData` in 32: store data, right-justified.
- `iRead` in 1: load request (level).
- `iWrite` in 1: store request (level).
- `iSize` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `iUnsigned` in 1: zero-extend loads when 1, sign-extend when 0.
- `oRData` out 32: load result.
- `oRdy` out 1: one-cycle completion pulse.
- `oMisalign` out 1: error flag, valid only while `oRdy` is high.
- `oRamAddr` out ADDR_W-2: word address, equal to `iAddr[ADDR_W-1:2]`.
- `oRamWData` out 32: lane-replicated write data.
- `oRamBe` out 4: byte enables; bit n covers bits [8n+7:8n].
- `oRamEn` out 1: RAM access strobe.
- `oRamWe` out 1: RAM write strobe, qualified by `oRamEn`.
- `iRamRData` in 32: RAM read data.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, DONE. Reset state is IDLE.
- **IDLE:**
  - Samples requests each cycle. If `iWrite` and `iRead` are both high, the write wins.
  - On a request, latches address, size, `iUnsigned` and data.
  - Next state is DONE if the request is misaligned, otherwise ACCESS.
- **Misaligned / illegal:** any of `iSize`=11, half with `iAddr[0]`=1, or word with `iAddr[1:0]`≠0.
  - Goes to DONE with `oMisalign`=1.
  - No RAM strobe is issued.
  - `oRData` is unchanged.
- **ACCESS:**
  - `oRamEn`=1 for exactly this one cycle; `oRamWe`=1 for writes.
  - Write: next state is DONE.
  - Read: loads the wait counter with WAIT_STATES, then goes to WAIT.
- **WAIT (reads only):**
  - Counter decrements each cycle.
  - On the cycle the counter equals 1, captures the lane-extracted result from `iRamRData` into `oRData`, then goes to DONE.
- **DONE:** `oRdy`=1 for one cycle; requests are ignored; next state is IDLE.
- **Request release:** the core drops its request in the DONE cycle. Any request still high in the following IDLE cycle is a new access.
- **Byte lanes (little-endian), with a = latched `addr[1:0]`:**
  - Byte: `oRamBe` = 1<<a; `oRamWData` = {4{wdata[7:0]}}.
  - Half: `oRamBe` = a[1] ? 1100 : 0011; `oRamWData` = {2{wdata[15:0]}}.
  - Word: `oRamBe` = 1111; `oRamWData` = wdata.
  - Reads: `oRamBe` = 1111.
- **Load extract:**
  - Byte: `rdata[8a+7:8a]`.
  - Half: `rdata[16a[1]+15:16a[1]]`.
  - The extracted value is extended to 32 bits: sign-extended when `iUnsigned`=0, zero-extended when 1.
- **Signal stability:** `oRamAddr`, `oRamBe` and `oRamWData` are registered and held stable from ACCESS through DONE.

## Timing
- **Reset values:** all outputs are 0, including `oRData`. State is IDLE and the counter is 0.
- **Reset mid-operation:** `nRst` low forces IDLE immediately (asynchronous).
  - `oRamEn` and `oRamWe` drop in the same cycle.
  - An in-flight access is abandoned; no `oRdy` is produced.
- **Latency**, counting the request-sampled cycle as 0:
  - Store: ACCESS in cycle 1, `oRdy` in cycle 2.
  - Load: ACCESS in cycle 1, WAIT in cycles 2..1+WAIT_STATES, `oRdy` in cycle 2+WAIT_STATES. With the default this is `oRdy` in cycle 3.
  - Misaligned or illegal: `oRdy` with `oMisalign`=1 in cycle 1.
- **Read data:** `oRData` is valid from the DONE cycle and holds until the next completed load.
- **Throughput:** back-to-back requests need at least one IDLE cycle between DONE and the next ACCESS. Store-to-store minimum period is 3 cycles.

## Test plan
- **Word store, then word load:**
  - Stimulus: store `iAddr`=0x100, `iWData`=0xDEADBEEF, size 10; then load the same address.
  - Store cycle 1: `oRamBe`=1111, `oRamAddr`=0x40.
  - Load: `oRdy` in cycle 3, `oRData`=0xDEADBEEF, `oMisalign`=0.
- **Byte store at offset 2:**
  - Stimulus: `iAddr`=0x102, `iWData`=0x000000A5, size 00.
  - Required: `oRamBe`=0100, `oRamWData`=0xA5A5A5A5, `oRamEn` high for exactly one cycle.
- **Sign vs zero extension:**
  - Setup: RAM word is 0x80F17F00.
  - Signed byte load at 0x2: 0xFFFFFFF1.
  - Unsigned byte load at 0x2: 0x000000F1.
  - Signed half load at 0x2: 0xFFFF80F1.
  - Unsigned half load at 0x0: 0x00007F00.
- **Misaligned and illegal rejection:**
  - Stimulus: word load at 0x101, half store at 0x103, size 11 at 0x0.
  - Each: `oRdy` and `oMisalign`=1 in cycle 1; `oRamEn` never asserts; `oRData` unchanged.
- **Wait-state sweep:**
  - Stimulus: WAIT_STATES = 1, 4, 15 with a RAM model of matching latency.
  - Required: load `oRdy` in cycle 2+WAIT_STATES with correct data. Simultaneous `iRead`/`iWrite` performs a write.
- **Async reset in WAIT:**
  - Stimulus: with WAIT_STATES=4, assert `nRst` low in cycle 3 of a load.
  - Required: all outputs 0 immediately and no `oRdy`. A new load after release completes normally.
